// File: rtl/random_vector_engine.sv
// LFSR stimulus generator with settle timer, MISR response compaction and a valid/ready capture stream.
// One vector per SETTLE_CYCLES+1 cycles at full rate; EMIT holds stimulus and response while resp_ready is low.
module random_vector_engine #(
  parameter int                   IN_WIDTH      = 32,
  parameter int                   OUT_WIDTH     = 32,
  parameter int                   NUM_TESTS     = 10000,
  parameter int                   SETTLE_CYCLES = 1,
  parameter logic [IN_WIDTH-1:0]  LFSR_TAPS     = IN_WIDTH'(32'h80200003),
  parameter logic [OUT_WIDTH-1:0] MISR_TAPS     = OUT_WIDTH'(32'h04C11DB7),
  parameter logic [IN_WIDTH-1:0]  SEED          = IN_WIDTH'(1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 seed_load,
  input  logic [IN_WIDTH-1:0]  seed,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [OUT_WIDTH-1:0] resp_data,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] signature,
  output logic [31:0]          test_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  // An all-zero LFSR would never leave zero, so zero seeds are replaced by 1.
  localparam logic [IN_WIDTH-1:0] RESET_LFSR = (SEED == '0) ? IN_WIDTH'(1) : SEED;

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;

  state_t               r_state, w_next_state;
  logic [IN_WIDTH-1:0]  r_lfsr, r_dut_in;
  logic [OUT_WIDTH-1:0] r_misr, r_resp_data;
  logic [CW-1:0]        r_cnt;
  logic [31:0]          r_test_count;

  logic                 w_idle_like, w_last_settle, w_handshake, w_final;
  logic [IN_WIDTH-1:0]  w_cur_lfsr, w_lfsr_step;
  logic [OUT_WIDTH-1:0] w_misr_step;
  logic [31:0]          w_count_inc;

  always_comb begin
    w_idle_like   = (r_state == IDLE) || (r_state == DONE);
    w_last_settle = (r_state == SETTLE) && (r_cnt == '0);
    w_handshake   = (r_state == EMIT) && resp_ready;
    w_count_inc   = r_test_count + 32'd1;
    w_final       = (w_count_inc == 32'(NUM_TESTS));
    w_lfsr_step   = {r_lfsr[IN_WIDTH-2:0], 1'b0} ^ (r_lfsr[IN_WIDTH-1] ? LFSR_TAPS : '0);
    w_misr_step   = {r_misr[OUT_WIDTH-2:0], 1'b0} ^ (r_misr[OUT_WIDTH-1] ? MISR_TAPS : '0) ^ dut_out;
    // A seed loaded alongside start must be the first vector of that run.
    w_cur_lfsr    = r_lfsr;
    if (seed_load && w_idle_like && !abort) begin
      w_cur_lfsr = (seed == '0) ? IN_WIDTH'(1) : seed;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) w_next_state = SETTLE;
        SETTLE:     if (w_last_settle) w_next_state = EMIT;
        EMIT:       if (w_handshake) w_next_state = w_final ? DONE : SETTLE;
        default:    w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr       <= RESET_LFSR;
      r_dut_in     <= '0;
      r_misr       <= '0;
      r_resp_data  <= '0;
      r_cnt        <= '0;
      r_test_count <= '0;
    end else if (!abort) begin
      case (r_state)
        IDLE, DONE: begin
          r_lfsr <= w_cur_lfsr;
          if (start) begin
            r_dut_in     <= w_cur_lfsr;
            r_misr       <= '0;
            r_test_count <= '0;
            r_cnt        <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_resp_data <= dut_out;
            r_misr      <= w_misr_step;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        EMIT: begin
          if (resp_ready) begin
            r_test_count <= w_count_inc;
            // The last vector of a run stays in the LFSR; the next run resumes from it.
            if (!w_final) begin
              r_lfsr   <= w_lfsr_step;
              r_dut_in <= w_lfsr_step;
              r_cnt    <= CNT_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_in     = r_dut_in;
  assign resp_data  = r_resp_data;
  assign resp_valid = (r_state == EMIT);
  assign busy       = (r_state == SETTLE) || (r_state == EMIT);
  assign done       = (r_state == DONE);
  assign signature  = r_misr;
  assign test_count = r_test_count;

endmodule

// File: tb/tb_random_vector_engine.sv
// Bench for random_vector_engine: transaction model of LFSR vectors and MISR signature,
// plus a SETTLE_CYCLES=4 instance probed with per-edge markers on dut_out.
module tb_random_vector_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, seed_load, resp_ready;
  logic [31:0] seed;
  logic [31:0] dut_in, dut_out, resp_data, signature, test_count;
  logic        resp_valid, busy, done;
  assign dut_out = dut_in;

  logic        start4, resp_ready4, zero1;
  logic [31:0] dut_out4, zero32;
  logic [31:0] dut_in4, resp_data4, signature4, test_count4;
  logic        resp_valid4, busy4, done4;
  assign zero1  = 1'b0;
  assign zero32 = 32'h0;

  random_vector_engine #(.NUM_TESTS(3), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_load(seed_load),
    .seed(seed), .dut_in(dut_in), .dut_out(dut_out), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy), .done(done),
    .signature(signature), .test_count(test_count));

  random_vector_engine #(.NUM_TESTS(3), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(zero1), .seed_load(zero1),
    .seed(zero32), .dut_in(dut_in4), .dut_out(dut_out4), .resp_valid(resp_valid4),
    .resp_ready(resp_ready4), .resp_data(resp_data4), .busy(busy4), .done(done4),
    .signature(signature4), .test_count(test_count4));

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];
  logic [31:0] m_lfsr;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] misr_of(input logic [31:0] r[$]);
    logic [31:0] m = 32'h0;
    foreach (r[i]) m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ r[i];
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired, want event", name);
  endtask

  // One full run of the model: NUM_TESTS vectors starting at the current LFSR value.
  task automatic push_run();
    logic [31:0] v = m_lfsr;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(v);
      if (i < 2) v = lfsr_next(v);
    end
    m_lfsr = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    if (!done) fail_now(name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!resp_valid) fail_now(name);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_data"}, resp_data, 32'h0);
    check({tag, "_dut_in"}, dut_in, 32'h0);
    check({tag, "_sig"}, signature, 32'h0);
    check({tag, "_count"}, test_count, 32'h0);
  endtask

  task automatic check_caps(input string tag, input logic [31:0] a, input logic [31:0] b);
    check({tag, "_ncap"}, 32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3) begin
      check({tag, "_cap0"}, cap_q[0], a);
      check({tag, "_cap1"}, cap_q[1], b);
    end
    check({tag, "_sig_model"}, signature, misr_of(cap_q));
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every accepted response must match the model's next vector (loopback).
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got %h, want no response", resp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", resp_data, e);
          check("dut_in_emit", dut_in, e);
          cap_q.push_back(resp_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first, held_in, held_d, held_s;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0; seed = 32'h0;
    resp_ready = 1'b0; start4 = 1'b0; resp_ready4 = 1'b0; dut_out4 = 32'h0;
    m_lfsr = 32'h1;
    #12;
    check_zero("reset");
    check("reset4_dut_in", dut_in4, 32'h0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Basic loopback run from SEED=1.
    resp_ready = 1'b1; cap_q.delete();
    push_run(); pulse_start(); wait_done("run1_done");
    check_caps("run1", 32'h1, 32'h2);
    if (cap_q.size() == 3) check("run1_cap2", cap_q[2], 32'h4);
    check("run1_sig", signature, 32'h4);
    check("run1_count", test_count, 32'd3);
    check("run1_done", 32'(done), 32'h1);
    check("run1_busy", 32'(busy), 32'h0);

    // Seed load together with start.
    cap_q.delete(); seed = 32'h80000000; seed_load = 1'b1; m_lfsr = seed;
    push_run(); pulse_start(); wait_done("run2_done");
    check_caps("run2", 32'h80000000, 32'h80200003);

    // Backpressure; start and seed_load while busy must be ignored.
    resp_ready = 1'b0; cap_q.delete();
    push_run(); pulse_start(); wait_valid("stall_valid");
    held_in = dut_in; held_d = resp_data; held_s = signature;
    check("stall_first", held_d, 32'h80600005);
    check("stall_sig_once", held_s, 32'h80600005);
    start = 1'b1; seed_load = 1'b1; seed = 32'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid_hold", 32'(resp_valid), 32'h1);
      check("stall_data_hold", resp_data, held_d);
      check("stall_in_hold", dut_in, held_in);
      check("stall_sig_hold", signature, held_s);
      check("stall_count_hold", test_count, 32'h0);
    end
    start = 1'b0; seed_load = 1'b0; resp_ready = 1'b1;
    wait_done("run3_done");
    check("run3_count", test_count, 32'd3);
    check("run3_sig_model", signature, misr_of(cap_q));

    // Abort in the SETTLE phase of vector 2.
    cap_q.delete(); first = m_lfsr;
    push_run(); pulse_start();
    n = 0;
    while (!(busy && !resp_valid && test_count == 32'd1) && n < 20) begin @(negedge clk); n++; end
    if (n == 20) fail_now("abort_reach");
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_valid", 32'(resp_valid), 32'h0);
    check("abort_count", test_count, 32'd1);
    check("abort_dut_in", dut_in, lfsr_next(first));
    check("abort_sig", signature, misr_of(cap_q));
    exp_q.delete();
    seed = 32'h0; seed_load = 1'b1; @(negedge clk); seed_load = 1'b0;
    m_lfsr = 32'h1; cap_q.delete();
    push_run(); pulse_start();
    check("zero_seed_first", dut_in, 32'h1);
    wait_done("run4_done");
    check("run4_sig", signature, 32'h4);

    // Asynchronous reset while in EMIT, then a clean rerun.
    resp_ready = 1'b0; pulse_start(); wait_valid("rst_valid");
    rst_n = 1'b0; #1;
    check_zero("rst_emit");
    exp_q.delete(); cap_q.delete(); m_lfsr = 32'h1;
    @(negedge clk); rst_n = 1'b1; resp_ready = 1'b1; @(negedge clk);
    push_run(); pulse_start(); wait_done("run5_done");
    check_caps("run5", 32'h1, 32'h2);
    check("run5_sig", signature, 32'h4);
    check("run5_count", test_count, 32'd3);

    // SETTLE_CYCLES=4: dut_out4 carries the index of the upcoming edge.
    dut_out4 = 32'hA0000000; start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      dut_out4 = 32'hA0000000 | 32'(k);
      check("s4_not_valid", 32'(resp_valid4), 32'h0);
      check("s4_dut_in", dut_in4, 32'h1);
      @(negedge clk);
    end
    check("s4_valid", 32'(resp_valid4), 32'h1);
    check("s4_data", resp_data4, 32'hA0000004);
    check("s4_sig", signature4, 32'hA0000004);
    check("s4_busy", 32'(busy4), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/random_vector_engine.md
RANDOM_VECTOR_ENGINE -- requirements
Module: random_vector_engine

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of stimulus vector (>=2).
REQ-002 SHALL have parameter OUT_WIDTH, default 32, width of DUT response (>=2).
REQ-003 SHALL have parameter NUM_TESTS, default 10000, vectors applied per run (>=1).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 1, cycles from stimulus change to response sample (>=1).
REQ-005 SHALL have parameter LFSR_TAPS, default 32'h80200003, Galois feedback mask, IN_WIDTH bits.
REQ-006 SHALL have parameter MISR_TAPS, default 32'h04C11DB7, MISR feedback mask, OUT_WIDTH bits.
REQ-007 SHALL have parameter SEED, default 1, LFSR reset value, IN_WIDTH bits.
REQ-008 Ports, in order: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous and active-low.
REQ-009 start in 1, begin run; abort in 1, terminate run; seed_load in 1, load seed; seed in IN_WIDTH, new LFSR value.
REQ-010 dut_in out IN_WIDTH, registered stimulus; dut_out in OUT_WIDTH, DUT response.
REQ-011 resp_valid out 1, resp_ready in 1, resp_data out OUT_WIDTH: captured-response stream.
REQ-012 busy out 1; done out 1; signature out OUT_WIDTH, MISR state; test_count out 32, vectors completed.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, EMIT, DONE.
REQ-014 LFSR step SHALL be next = {lfsr[IN_WIDTH-2:0],0} XOR (lfsr[IN_WIDTH-1] ? LFSR_TAPS : 0).
REQ-015 MISR step SHALL be next = {misr[OUT_WIDTH-2:0],0} XOR (misr[OUT_WIDTH-1] ? MISR_TAPS : 0) XOR dut_out.
REQ-016 seed_load SHALL be honoured only in IDLE/DONE; seed of all-zero SHALL load 1 (no lockup); ignored while busy.
REQ-017 start in IDLE/DONE SHALL: clear done, misr, test_count; load dut_in with current lfsr; load settle counter; enter SETTLE; assert busy.
REQ-018 Run SHALL continue from current LFSR state; start does not reseed.
REQ-019 start while busy SHALL be ignored.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its final edge dut_out SHALL be sampled into resp_data and MISR updated once; enter EMIT.
REQ-021 EMIT SHALL hold resp_valid=1 with resp_data, dut_in stable until resp_valid & resp_ready.
REQ-022 On handshake: test_count +1; if new count == NUM_TESTS go DONE, else advance lfsr, drive dut_in with next value, reload counter, enter SETTLE.
REQ-023 resp_valid SHALL deassert the cycle after handshake; no MISR update outside REQ-020 edge.
REQ-024 DONE SHALL hold done=1, busy=0, signature and test_count stable until next start or reset.
REQ-025 abort (priority over all else) SHALL move to IDLE next edge: busy=0, resp_valid=0, done=0; signature, test_count, lfsr, dut_in retained.
REQ-026 abort in IDLE/DONE SHALL have no effect except clearing done.
REQ-027 seed_load and start in same cycle: seed SHALL load first, run starts from loaded seed.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, lfsr=SEED (zero replaced by 1), misr=0, dut_in=0, resp_data=0, resp_valid=0, busy=0, done=0, test_count=0.
REQ-029 Reset mid-run SHALL discard the run with no done pulse; first start after release uses SEED.

Verification
REQ-030 NUM_TESTS=3, SETTLE_CYCLES=1, SEED=1, dut_out=dut_in loopback, resp_ready=1 -> resp_data 1,2,4; signature 4; test_count 3; done=1.
REQ-031 seed_load seed=32'h80000000 then start, loopback -> resp_data 32'h80000000 then 32'h80200003.
REQ-032 resp_ready low 5 cycles in EMIT -> resp_valid, resp_data, dut_in held; signature changes once only.
REQ-033 SETTLE_CYCLES=4 -> dut_out sampled exactly 4 edges after dut_in change; glitch on dut_out at edge 2 not captured.
REQ-034 abort during SETTLE of vector 2 -> IDLE next cycle, busy=0, done=0, test_count=1; seed_load 0 -> lfsr=1.
REQ-035 rst_n low during EMIT -> all outputs zero asynchronously, restart reproduces REQ-030 sequence.
